// File: rtl/write_buffer.sv
// Write-through store buffer: FIFO of {addr,data} stores drained to memory, with
// combinational store-to-load forwarding lookup. Optional merging via WRITE_MERGE_EN.
module write_buffer #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_data,
  input  logic [ADDR_W-1:0]          lk_addr,
  output logic                       lk_hit,
  output logic [DATA_W-1:0]          lk_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [15:0]                merge_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [IDX_W-1:0]  newest_idx;
  logic [IDX_W-1:0]  lk_slot;
  logic              merge_ok;
  logic              push;
  logic              pop;

  assign count      = wr_ptr_q - rd_ptr_q;
  assign full       = (count == PTR_W'(DEPTH));
  assign empty      = (count == '0);
  assign newest_idx = IDX_W'(wr_ptr_q - PTR_W'(1));

`ifdef WRITE_MERGE_EN
  logic [15:0] merge_count_q, merge_count_d;

  // The newest entry must not be the head, otherwise memory could see its data change.
  assign merge_ok    = (count >= PTR_W'(2)) && (addr_q[newest_idx] == wr_addr);
  assign merge_count = merge_count_q;

  always_comb begin
    merge_count_d = merge_count_q;
    if (push && merge_ok && (merge_count_q != 16'hFFFF)) merge_count_d = merge_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) merge_count_q <= '0;
    else        merge_count_q <= merge_count_d;
  end
`else
  assign merge_ok    = 1'b0;
  assign merge_count = '0;
`endif

  assign wr_ready  = !full || merge_ok;
  assign mem_valid = !empty;
  assign mem_addr  = addr_q[rd_ptr_q[IDX_W-1:0]];
  assign mem_data  = data_q[rd_ptr_q[IDX_W-1:0]];
  assign push      = wr_valid && wr_ready;
  assign pop       = mem_valid && mem_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (push) begin
      if (merge_ok) begin
        data_d[newest_idx] = wr_data;
      end else begin
        addr_d[wr_ptr_q[IDX_W-1:0]] = wr_addr;
        data_d[wr_ptr_q[IDX_W-1:0]] = wr_data;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    lk_slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_slot = IDX_W'(rd_ptr_q + PTR_W'(i));
      if ((PTR_W'(i) < count) && (addr_q[lk_slot] == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = data_q[lk_slot];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= '{default: '0};
      data_q   <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Scoreboard bench for write_buffer: stimulus queues expected drain entries,
// a negedge monitor compares every accepted memory transfer.
module tb_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [14:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [14:0] mem_addr;
  logic [31:0] mem_data;
  logic [14:0] lk_addr = '0;
  logic        lk_hit;
  logic [31:0] lk_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic [15:0] merge_count;

  int vectors = 0;
  int miscompares = 0;
  logic [46:0] exp_q [$];

  always #5 clk = ~clk;

  write_buffer #(.ADDR_W(15), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
    .count(count), .full(full), .empty(empty), .merge_count(merge_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Every transfer the DUT hands to memory must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n && mem_valid && mem_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL drain: unexpected transfer addr 0x%0h data 0x%0h", mem_addr, mem_data);
      end else begin
        logic [46:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} !== e) begin
          miscompares++;
          $display("FAIL drain: got 0x%0h/0x%0h, expected 0x%0h/0x%0h",
                   mem_addr, mem_data, e[46:32], e[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [14:0] a, input logic [31:0] d);
    logic rdy;
    logic done;
    done = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      rdy = wr_ready;
      step();
      if (rdy) done = 1'b1;
    end
    wr_valid = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: store 0x%0h never accepted", a);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    mem_ready = 1'b1;
    while (!empty && n < 50) begin
      step();
      n++;
    end
    mem_ready = 1'b0;
    check("drain_done_empty", {31'd0, empty}, 32'd1);
  endtask

  initial begin
    // 1. reset state
    #3;
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_merge_count", {16'd0, merge_count}, 32'd0);
    check("rst_lk_hit", {31'd0, lk_hit}, 32'd0);
    check("rst_lk_data", lk_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 2 + 4. fill, full behaviour, pop while full refuses push
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({15'h0010 + 15'(i), 32'hA0 + 32'(i)});
      push(15'h0010 + 15'(i), 32'hA0 + 32'(i));
    end
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("fill_count", {29'd0, count}, 32'd4);
    wr_valid = 1'b1;
    wr_addr  = 15'h0014;
    wr_data  = 32'hA4;
    exp_q.push_back({15'h0014, 32'hA4});
    step();
    check("held_count", {29'd0, count}, 32'd4);
    check("held_mem_addr", {17'd0, mem_addr}, 32'h0010);
    check("held_mem_data", mem_data, 32'hA0);
    mem_ready = 1'b1;
    step();
    check("popfull_count", {29'd0, count}, 32'd3);
    check("popfull_wr_ready", {31'd0, wr_ready}, 32'd1);
    step();
    wr_valid = 1'b0;
    check("pushpop_count", {29'd0, count}, 32'd3);
    drain();

    // 3. forwarding, youngest match wins, same-cycle push invisible
    exp_q.push_back({15'h1234, 32'hD1});
    push(15'h1234, 32'hD1);
    exp_q.push_back({15'h0001, 32'hE0});
    wr_valid = 1'b1;
    wr_addr  = 15'h0001;
    wr_data  = 32'hE0;
    lk_addr  = 15'h0001;
    #1;
    check("lk_same_cycle_hit", {31'd0, lk_hit}, 32'd0);
    step();
    wr_valid = 1'b0;
    check("lk_next_cycle_hit", {31'd0, lk_hit}, 32'd1);
    check("lk_next_cycle_data", lk_data, 32'hE0);
    exp_q.push_back({15'h1234, 32'hD2});
    push(15'h1234, 32'hD2);
    lk_addr = 15'h1234;
    #1;
    check("lk_young_hit", {31'd0, lk_hit}, 32'd1);
    check("lk_young_data", lk_data, 32'hD2);
    lk_addr = 15'h7FFF;
    #1;
    check("lk_miss_hit", {31'd0, lk_hit}, 32'd0);
    check("lk_miss_data", lk_data, 32'd0);
    lk_addr = 15'h1234;
    mem_ready = 1'b1;
    step();
    step();
    mem_ready = 1'b0;
    #1;
    check("lk_after_pop_data", lk_data, 32'hD2);
    drain();
    lk_addr = 15'h0000;

    // 5. reset mid-operation discards everything
    push(15'h0020, 32'hC0);
    push(15'h0021, 32'hC1);
    push(15'h0022, 32'hC2);
    check("pre_rst_mem_valid", {31'd0, mem_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("midrst_count", {29'd0, count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    mem_ready = 1'b0;
    check("postrst_empty", {31'd0, empty}, 32'd1);

    // 6. merge into newest non-head entry
    exp_q.push_back({15'h0005, 32'h11});
    push(15'h0005, 32'h11);
    push(15'h0006, 32'h22);
`ifdef WRITE_MERGE_EN
    push(15'h0006, 32'h33);
    exp_q.push_back({15'h0006, 32'h33});
    check("merge_count_val", {29'd0, count}, 32'd2);
    check("merge_counter", {16'd0, merge_count}, 32'd1);
    exp_q.push_back({15'h0007, 32'h44});
    push(15'h0007, 32'h44);
    push(15'h0008, 32'h55);
    check("merge_fill_full", {31'd0, full}, 32'd1);
    wr_valid = 1'b1;
    wr_addr  = 15'h0008;
    wr_data  = 32'h66;
    #1;
    check("merge_full_wr_ready", {31'd0, wr_ready}, 32'd1);
    step();
    wr_valid = 1'b0;
    exp_q.push_back({15'h0008, 32'h66});
    check("merge_full_count", {29'd0, count}, 32'd4);
    check("merge_full_counter", {16'd0, merge_count}, 32'd2);
`else
    exp_q.push_back({15'h0006, 32'h22});
    exp_q.push_back({15'h0006, 32'h33});
    push(15'h0006, 32'h33);
    check("nomerge_count", {29'd0, count}, 32'd3);
    check("nomerge_counter", {16'd0, merge_count}, 32'd0);
`endif
    drain();
    step();
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
